lc4_branch_resolve: RTL and testbench
=====================================

Name: lc4_branch_resolve

Overview:
- Downstream neighbour of the execute-stage ALU in the two-way superscalar LC4 pipeline.
- Consumes each pipe's ALU result and register write-back value, and holds the architectural NZP register.
- Resolves conditional and unconditional control transfers for the bundle, pipe A older than pipe B.
- Issues a registered PC redirect, then squashes the wrong-path bundles that follow it.

Parameters:
- SHADOW_CYCLES, 1, number of bundles after a redirect whose inputs are ignored (1..3).
- PC_W, 16, PC/data width (fixed at 16 for LC4; parameterised for bench only).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-low
- gwe  in  1  global write enable; 0 freezes every register in the block
- i_valid_a / i_valid_b  in  1  pipe A/B holds a real instruction
- i_insn_a / i_insn_b  in  16  instruction word
- i_alu_a / i_alu_b  in  16  ALU o_result (branch/jump target for control insns)
- i_wdata_a / i_wdata_b  in  16  final register write value (ALU result, load data or PC+1)
- i_nzp_we_a / i_nzp_we_b  in  1  decoded "this insn sets NZP"
- o_nzp  out  3  architectural NZP {N,Z,P}
- o_redirect  out  1  registered one-cycle redirect pulse
- o_target  out  16  redirect PC, valid while o_redirect=1
- o_squash_b  out  1  combinational: pipe B of current bundle must not retire
- o_shadow  out  1  current bundle is in the shadow and is ignored

Behaviour:
- Reset (rst_n=0 at posedge): o_nzp=3'b010, o_redirect=0, o_target=16'h0000, shadow counter=0. Reset has priority over gwe.
- NZP of value v: N=v[15], Z=(v==0), P=!N&&!Z.
- Decode per pipe:
  - opcode 0000 with insn[11:9]!=0 is a conditional BR.
  - opcode 0000 with insn[11:9]=000 is a NOP and never taken.
  - opcodes 0100 (JSR/JSRR), 1100 (JMP/JMPR), 1000 (RTI) and 1111 (TRAP) are always taken.
- Effective valid: ev_a = i_valid_a && !shadow; ev_b = i_valid_b && !shadow && !taken_a.
- Pipe A BR taken = |(insn_a[11:9] & o_nzp).
- Pipe B BR uses the bypassed NZP:
  - NZP(i_wdata_a) if ev_a && i_nzp_we_a;
  - else o_nzp.
- taken_a/taken_b are gated by ev_a/ev_b. o_squash_b = shadow || taken_a.
- Next-cycle NZP:
  - NZP(wdata_b) if ev_b && nzp_we_b;
  - else NZP(wdata_a) if ev_a && nzp_we_a;
  - else hold.
- A JSR/TRAP that sets NZP updates it from i_wdata (PC+1), never from i_alu.
- Redirect register:
  - If taken_a: o_redirect<=1, o_target<=i_alu_a.
  - Else if taken_b: o_redirect<=1, o_target<=i_alu_b.
  - Else o_redirect<=0 and o_target holds its value.
- Latency: one cycle from bundle presentation to o_redirect.
- Shadow counter:
  - Loaded with SHADOW_CYCLES on the same edge that sets o_redirect.
  - Decrements each gwe cycle while nonzero. o_shadow = (counter!=0).
  - While shadowed, no NZP update and no new redirect.
- Boundaries:
  - Both pipes taken: A wins, B squashed, and B's NZP write is dropped.
  - A taken and also writes NZP (e.g. TRAP): A's update is applied.
  - gwe=0: all state holds and o_redirect stays at its current level; the pulse is counted in gwe cycles.
  - Reset mid-shadow: counter cleared and the next bundle is evaluated normally.
  - Redirect target is not range-checked; privilege faults are handled elsewhere.

Optional Feature:
- Macro LC4_BR_PERF_EN.
- Defined:
  - Adds outputs o_br_count[15:0] and o_br_taken[15:0].
  - o_br_count counts effective conditional BRs resolved, up to 2 per cycle.
  - o_br_taken counts those taken.
  - Both saturate at 16'hFFFF, reset to 0 and are frozen when gwe=0.
- Undefined: ports and counters are absent and there is no other behavioural change.

Decomposition:
- Shared package lc4_pkg holds:
  - opcode constants OP_BR=4'b0000, OP_JSR=4'b0100, OP_RTI=4'b1000, OP_JMP=4'b1100, OP_TRAP=4'b1111;
  - a 3-bit nzp_t typedef;
  - the NZP reset constant NZP_RST=3'b010.
- One sub-module, lc4_nzp_gen: 16-bit value in, nzp_t out, combinational.
- It is instantiated twice, once for wdata_a and once for wdata_b.

Test Plan:
- After reset, o_nzp=010. A: BRz (insn 16'h0405), i_alu_a=16'h0030 -> next cycle o_redirect=1, o_target=0030.
- Shadow: the bundle after that redirect is A: ADD with wdata 16'h8000, nzp_we=1 -> o_shadow=1 and o_nzp stays 010.
- Intra-bundle bypass, o_nzp=010:
  - A: ADD with wdata 16'hFFFF and nzp_we=1; B: BRn with i_alu_b=16'h1234.
  - Required: o_target=1234 next cycle and o_nzp=100.
- Both taken: A: JMP with alu 16'h0200, B: TRAP -> o_squash_b=1, o_target=0200, and o_nzp not updated from B.
- Stall and reset: with gwe=0 for 3 cycles after a redirect, o_redirect is held high and o_nzp is unchanged. Then rst_n=0 mid-shadow -> o_shadow=0, o_redirect=0, o_nzp=010.
- With LC4_BR_PERF_EN: 5 BRs in which 2 are taken, plus 1 NOP (16'h0000) -> o_br_count=5, o_br_taken=2.

Source files
------------

// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: opcode constants, the NZP type and its reset value,
// and a decode helper for the always-taken control transfers.
package lc4_pkg;

    typedef logic [2:0] nzp_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam nzp_t NZP_RST = 3'b010;

    function automatic logic is_uncond(input logic [3:0] opcode);
        return (opcode == OP_JSR) || (opcode == OP_JMP) ||
               (opcode == OP_RTI) || (opcode == OP_TRAP);
    endfunction

endpackage

// File: rtl/lc4_nzp_gen.sv
// Combinational NZP flag generation from a two's-complement value.
module lc4_nzp_gen
    import lc4_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    output nzp_t         nzp
);

    logic n;
    logic z;

    assign n   = value[W-1];
    assign z   = (value == '0);
    assign nzp = {n, z, ~n & ~z};

endmodule

// File: rtl/lc4_branch_resolve.sv
// Branch resolution for the two-way LC4 pipeline: NZP register, registered
// PC redirect and wrong-path shadow. Optional counters under LC4_BR_PERF_EN.
module lc4_branch_resolve
    import lc4_pkg::*;
#(
    parameter int SHADOW_CYCLES = 1,
    parameter int PC_W          = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gwe,
    input  logic            i_valid_a,
    input  logic            i_valid_b,
    input  logic [15:0]     i_insn_a,
    input  logic [15:0]     i_insn_b,
    input  logic [PC_W-1:0] i_alu_a,
    input  logic [PC_W-1:0] i_alu_b,
    input  logic [PC_W-1:0] i_wdata_a,
    input  logic [PC_W-1:0] i_wdata_b,
    input  logic            i_nzp_we_a,
    input  logic            i_nzp_we_b,
    output logic [2:0]      o_nzp,
    output logic            o_redirect,
    output logic [PC_W-1:0] o_target,
    output logic            o_squash_b,
`ifdef LC4_BR_PERF_EN
    output logic [15:0]     o_br_count,
    output logic [15:0]     o_br_taken,
`endif
    output logic            o_shadow
);

    logic [1:0] shadow_cnt;
    nzp_t       nzp_a;
    nzp_t       nzp_b;
    nzp_t       nzp_for_b;
    nzp_t       nzp_next;
    logic       ev_a;
    logic       ev_b;
    logic       br_a;
    logic       br_b;
    logic       cond_a;
    logic       cond_b;
    logic       taken_a;
    logic       taken_b;

    lc4_nzp_gen #(.W(PC_W)) u_nzp_a (.value(i_wdata_a), .nzp(nzp_a));
    lc4_nzp_gen #(.W(PC_W)) u_nzp_b (.value(i_wdata_b), .nzp(nzp_b));

    assign o_shadow = (shadow_cnt != 2'd0);

    // A NOP is opcode BR with an empty condition mask, so it never counts as a BR.
    assign br_a = (i_insn_a[15:12] == OP_BR) && (i_insn_a[11:9] != 3'b000);
    assign br_b = (i_insn_b[15:12] == OP_BR) && (i_insn_b[11:9] != 3'b000);

    assign ev_a = i_valid_a && !o_shadow;
    assign ev_b = i_valid_b && !o_shadow && !taken_a;

    // Pipe B sees pipe A's flag write from the same bundle.
    assign nzp_for_b = (ev_a && i_nzp_we_a) ? nzp_a : o_nzp;

    assign cond_a = br_a && |(i_insn_a[11:9] & o_nzp);
    assign cond_b = br_b && |(i_insn_b[11:9] & nzp_for_b);

    assign taken_a = ev_a && (is_uncond(i_insn_a[15:12]) || cond_a);
    assign taken_b = ev_b && (is_uncond(i_insn_b[15:12]) || cond_b);

    assign o_squash_b = o_shadow || taken_a;

    always_comb begin
        nzp_next = o_nzp;
        if (ev_b && i_nzp_we_b) begin
            nzp_next = nzp_b;
        end else if (ev_a && i_nzp_we_a) begin
            nzp_next = nzp_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_nzp      <= NZP_RST;
            o_redirect <= 1'b0;
            o_target   <= '0;
            shadow_cnt <= 2'd0;
        end else if (gwe) begin
            o_nzp <= nzp_next;
            if (taken_a) begin
                o_redirect <= 1'b1;
                o_target   <= i_alu_a;
            end else if (taken_b) begin
                o_redirect <= 1'b1;
                o_target   <= i_alu_b;
            end else begin
                o_redirect <= 1'b0;
            end
            if (taken_a || taken_b) begin
                shadow_cnt <= 2'(SHADOW_CYCLES);
            end else if (shadow_cnt != 2'd0) begin
                shadow_cnt <= shadow_cnt - 2'd1;
            end
        end
    end

`ifdef LC4_BR_PERF_EN
    logic        res_a;
    logic        res_b;
    logic        tkn_a;
    logic        tkn_b;
    logic [16:0] count_sum;
    logic [16:0] taken_sum;

    assign res_a = ev_a && br_a;
    assign res_b = ev_b && br_b;
    assign tkn_a = res_a && cond_a;
    assign tkn_b = res_b && cond_b;

    assign count_sum = {1'b0, o_br_count} + 17'(res_a) + 17'(res_b);
    assign taken_sum = {1'b0, o_br_taken} + 17'(tkn_a) + 17'(tkn_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_br_count <= 16'd0;
            o_br_taken <= 16'd0;
        end else if (gwe) begin
            o_br_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
            o_br_taken <= taken_sum[16] ? 16'hFFFF : taken_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_lc4_branch_resolve.sv
// Directed self-checking bench for lc4_branch_resolve (default SHADOW_CYCLES=1).
module tb_lc4_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gwe;
    logic        i_valid_a, i_valid_b;
    logic [15:0] i_insn_a, i_insn_b;
    logic [15:0] i_alu_a, i_alu_b;
    logic [15:0] i_wdata_a, i_wdata_b;
    logic        i_nzp_we_a, i_nzp_we_b;
    logic [2:0]  o_nzp;
    logic        o_redirect;
    logic [15:0] o_target;
    logic        o_squash_b;
    logic        o_shadow;
`ifdef LC4_BR_PERF_EN
    logic [15:0] o_br_count;
    logic [15:0] o_br_taken;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [15:0] INSN_ADD  = 16'h1000;
    localparam logic [15:0] INSN_BRZ  = 16'h0405;
    localparam logic [15:0] INSN_BRN  = 16'h0801;
    localparam logic [15:0] INSN_BRP  = 16'h0201;
    localparam logic [15:0] INSN_BRA  = 16'h0E00;
    localparam logic [15:0] INSN_NOP  = 16'h0000;
    localparam logic [15:0] INSN_JMP  = 16'hC000;
    localparam logic [15:0] INSN_TRAP = 16'hF025;
    localparam logic [15:0] INSN_JSR  = 16'h4800;

    always #5 clk = ~clk;

    lc4_branch_resolve dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gwe        (gwe),
        .i_valid_a  (i_valid_a),
        .i_valid_b  (i_valid_b),
        .i_insn_a   (i_insn_a),
        .i_insn_b   (i_insn_b),
        .i_alu_a    (i_alu_a),
        .i_alu_b    (i_alu_b),
        .i_wdata_a  (i_wdata_a),
        .i_wdata_b  (i_wdata_b),
        .i_nzp_we_a (i_nzp_we_a),
        .i_nzp_we_b (i_nzp_we_b),
        .o_nzp      (o_nzp),
        .o_redirect (o_redirect),
        .o_target   (o_target),
        .o_squash_b (o_squash_b),
`ifdef LC4_BR_PERF_EN
        .o_br_count (o_br_count),
        .o_br_taken (o_br_taken),
`endif
        .o_shadow   (o_shadow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic va, input logic [15:0] ia, input logic [15:0] aa, input logic [15:0] wa, input logic wea,
        input logic vb, input logic [15:0] ib, input logic [15:0] ab, input logic [15:0] wb, input logic web);
        i_valid_a = va; i_insn_a = ia; i_alu_a = aa; i_wdata_a = wa; i_nzp_we_a = wea;
        i_valid_b = vb; i_insn_b = ib; i_alu_b = ab; i_wdata_b = wb; i_nzp_we_b = web;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        gwe   = 1'b1;
        idle();
        tick();
        checkOutput("rst_nzp", 32'(o_nzp), 32'h2);
        checkOutput("rst_redirect", 32'(o_redirect), 32'h0);
        checkOutput("rst_target", 32'(o_target), 32'h0);
        checkOutput("rst_shadow", 32'(o_shadow), 32'h0);

        // BRz with Z set after reset
        rst_n = 1'b1;
        applyStimulus(1'b1, INSN_BRZ, 16'h0030, 16'h0, 1'b0, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        checkOutput("brz_squash_b", 32'(o_squash_b), 32'h1);
        tick();
        checkOutput("brz_redirect", 32'(o_redirect), 32'h1);
        checkOutput("brz_target", 32'(o_target), 32'h0030);
        checkOutput("brz_shadow", 32'(o_shadow), 32'h1);

        // shadowed bundle must not touch NZP
        applyStimulus(1'b1, INSN_ADD, 16'h8000, 16'h8000, 1'b1, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        checkOutput("shadow_flag", 32'(o_shadow), 32'h1);
        checkOutput("shadow_squash_b", 32'(o_squash_b), 32'h1);
        tick();
        checkOutput("shadow_nzp", 32'(o_nzp), 32'h2);
        checkOutput("shadow_redirect_drop", 32'(o_redirect), 32'h0);
        checkOutput("shadow_target_hold", 32'(o_target), 32'h0030);
        checkOutput("shadow_clear", 32'(o_shadow), 32'h0);

        // intra-bundle bypass: A makes N, B BRn taken
        applyStimulus(1'b1, INSN_ADD, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, INSN_BRN, 16'h1234, 16'h0, 1'b0);
        checkOutput("bypass_squash_b", 32'(o_squash_b), 32'h0);
        tick();
        checkOutput("bypass_redirect", 32'(o_redirect), 32'h1);
        checkOutput("bypass_target", 32'(o_target), 32'h1234);
        checkOutput("bypass_nzp", 32'(o_nzp), 32'h4);
        idle();
        tick();

        // both taken: A wins, B's NZP write dropped
        applyStimulus(1'b1, INSN_JMP, 16'h0200, 16'h0, 1'b0, 1'b1, INSN_TRAP, 16'h5555, 16'h0000, 1'b1);
        checkOutput("both_squash_b", 32'(o_squash_b), 32'h1);
        tick();
        checkOutput("both_target", 32'(o_target), 32'h0200);
        checkOutput("both_nzp", 32'(o_nzp), 32'h4);
        idle();
        tick();

        // taken TRAP updates NZP from wdata (P), not from alu (N)
        applyStimulus(1'b1, INSN_TRAP, 16'h8000, 16'h0001, 1'b1, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("trap_target", 32'(o_target), 32'h8000);
        checkOutput("trap_nzp", 32'(o_nzp), 32'h1);
        idle();
        tick();

        // NOP never taken; B BRp must see bypassed Z, not stale P
        applyStimulus(1'b1, INSN_NOP, 16'h0999, 16'h0000, 1'b1, 1'b1, INSN_BRP, 16'h0777, 16'h0, 1'b0);
        tick();
        checkOutput("nottaken_redirect", 32'(o_redirect), 32'h0);
        checkOutput("nottaken_nzp", 32'(o_nzp), 32'h2);
        checkOutput("nottaken_target_hold", 32'(o_target), 32'h8000);

        // JSR redirect, then stall three cycles
        applyStimulus(1'b1, INSN_JSR, 16'h0100, 16'h0042, 1'b1, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("jsr_redirect", 32'(o_redirect), 32'h1);
        checkOutput("jsr_nzp", 32'(o_nzp), 32'h1);
        gwe = 1'b0;
        applyStimulus(1'b1, INSN_ADD, 16'h8000, 16'h8000, 1'b1, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_redirect", i), 32'(o_redirect), 32'h1);
            checkOutput($sformatf("stall%0d_nzp", i), 32'(o_nzp), 32'h1);
            checkOutput($sformatf("stall%0d_shadow", i), 32'(o_shadow), 32'h1);
        end

        // reset mid-shadow with gwe still low
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_shadow", 32'(o_shadow), 32'h0);
        checkOutput("midrst_redirect", 32'(o_redirect), 32'h0);
        checkOutput("midrst_nzp", 32'(o_nzp), 32'h2);
        rst_n = 1'b1;
        gwe   = 1'b1;
        applyStimulus(1'b1, INSN_BRZ, 16'h0044, 16'h0, 1'b0, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("postrst_redirect", 32'(o_redirect), 32'h1);
        checkOutput("postrst_target", 32'(o_target), 32'h0044);

`ifdef LC4_BR_PERF_EN
        rst_n = 1'b0;
        idle();
        tick();
        checkOutput("perf_rst_count", 32'(o_br_count), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, INSN_BRN, 16'h0, 16'h0, 1'b0, 1'b1, INSN_BRP, 16'h0, 16'h0, 1'b0);
        tick();
        applyStimulus(1'b1, INSN_BRZ, 16'h0300, 16'h0, 1'b0, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(1'b1, INSN_NOP, 16'h0, 16'h0, 1'b0, 1'b1, INSN_BRN, 16'h0, 16'h0, 1'b0);
        tick();
        applyStimulus(1'b1, INSN_BRA, 16'h0400, 16'h0, 1'b0, 1'b0, INSN_NOP, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        tick();
        checkOutput("perf_count", 32'(o_br_count), 32'd5);
        checkOutput("perf_taken", 32'(o_br_taken), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
